// File: rtl/alarm_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : alarm_controller_if
// Description : Lane-side bundle of the alarm controller. It carries the lane
//               counts, targets and acks, and returns the alarm LEDs and the
//               active lane.
// Revision    : 1.0 - initial release
// ============================================================================
interface alarm_controller_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);
    localparam int c_CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH*CNT_W-1:0] current_count;
    logic [N_CH*CNT_W-1:0] target_count;
    logic [N_CH-1:0]       ack;
    logic [N_CH-1:0]       alarm;
    logic [c_CH_W-1:0]     active_ch;

    modport master (output current_count, target_count, ack, input alarm, active_ch);
    modport slave  (input current_count, target_count, ack, output alarm, active_ch);
endinterface
`default_nettype wire

// File: rtl/alarm_controller.sv
`default_nettype none
// ============================================================================
// Module      : alarm_controller
// Description : Multi-lane bottle-full alarm. It arbitrates pending lanes
//               round-robin onto one buzzer, and a fault input preempts with a
//               continuous tone.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_controller #(
    parameter int N_CH       = 4,
    parameter int CNT_W      = 8,
    parameter int DIV_W      = 16,
    parameter int NUM_W      = 4,
    parameter int AUTO_CLEAR = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 fault,
    input  logic [DIV_W-1:0]     tone_div,
    input  logic [DIV_W-1:0]     beep_len,
    input  logic [DIV_W-1:0]     beep_gap,
    input  logic [NUM_W-1:0]     beep_num,
    alarm_controller_if.slave    lane_if,
    output logic                 buzzer,
    output logic                 busy
);
    localparam int c_CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int c_SW   = c_CH_W + 1;

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_BEEP_ON  = 2'd1;
    localparam logic [1:0] c_BEEP_OFF = 2'd2;
    localparam logic [1:0] c_FAULT    = 2'd3;

    logic [N_CH-1:0]   w_match, r_match_q, w_rise, r_pending, w_pend_nxt, w_clr;
    logic [1:0]        r_state, w_state_nxt;
    logic [DIV_W-1:0]  r_tmr, w_tmr_nxt, r_tone, w_tone_nxt;
    logic [DIV_W-1:0]  r_len, w_len_nxt, r_gap, w_gap_nxt, r_div, w_div_nxt;
    logic [NUM_W-1:0]  r_beeps, w_beeps_nxt, r_num, w_num_nxt;
    logic [c_CH_W-1:0] r_active_ch, w_active_nxt, r_rr, w_rr_nxt, w_pick;
    logic [c_SW-1:0]   w_sum;
    logic              r_buzzer, w_buz_nxt, r_busy, w_found, w_last, w_done, w_abort;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_lane
        assign w_match[gi] =
            (lane_if.current_count[gi*CNT_W +: CNT_W] == lane_if.target_count[gi*CNT_W +: CNT_W]) &&
            (lane_if.target_count[gi*CNT_W +: CNT_W] != '0);
    end

    assign w_rise  = w_match & ~r_match_q;
    assign w_last  = (r_beeps + 1'b1) == r_num;
    assign w_done  = (r_state == c_BEEP_OFF) && (r_tmr == r_gap) && w_last;
    assign w_clr   = ((AUTO_CLEAR != 0) && w_done && enable && !fault) ?
                     (N_CH'(1) << r_active_ch) : '0;
    // A rise in the same cycle as a clear wins so that no event is lost
    assign w_pend_nxt = (r_pending & ~lane_if.ack & ~w_clr) | w_rise;
    assign w_abort    = ~w_pend_nxt[r_active_ch];

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_sum = {1'b0, r_rr} + c_SW'(k);
            if (w_sum >= c_SW'(N_CH)) w_sum = w_sum - c_SW'(N_CH);
            if (!w_found && r_pending[w_sum[c_CH_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[c_CH_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_tmr_nxt    = r_tmr;
        w_tone_nxt   = r_tone;
        w_buz_nxt    = r_buzzer;
        w_beeps_nxt  = r_beeps;
        w_active_nxt = r_active_ch;
        w_rr_nxt     = r_rr;
        w_len_nxt    = r_len;
        w_gap_nxt    = r_gap;
        w_div_nxt    = r_div;
        w_num_nxt    = r_num;
        if (!enable) begin
            w_state_nxt = c_IDLE;
            w_tmr_nxt   = '0;
            w_tone_nxt  = '0;
            w_buz_nxt   = 1'b0;
            w_beeps_nxt = '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (fault) begin
                        w_state_nxt = c_FAULT;
                        w_tmr_nxt   = '0;
                        w_tone_nxt  = '0;
                        w_buz_nxt   = 1'b0;
                        w_div_nxt   = tone_div >> 1;
                    end else if (w_found) begin
                        w_state_nxt  = c_BEEP_ON;
                        w_active_nxt = w_pick;
                        w_rr_nxt     = (w_pick == c_CH_W'(N_CH - 1)) ? '0 : w_pick + 1'b1;
                        w_beeps_nxt  = '0;
                        w_tmr_nxt    = '0;
                        w_tone_nxt   = '0;
                        w_buz_nxt    = 1'b0;
                        w_len_nxt    = beep_len;
                        w_div_nxt    = tone_div;
                        w_num_nxt    = (beep_num == '0) ? NUM_W'(1) : beep_num;
                    end
                end
                c_BEEP_ON, c_BEEP_OFF: begin
                    if (fault) begin
                        w_state_nxt = c_FAULT;
                        w_tmr_nxt   = '0;
                        w_tone_nxt  = '0;
                        w_buz_nxt   = 1'b0;
                        w_beeps_nxt = '0;
                        w_div_nxt   = tone_div >> 1;
                    end else if (w_abort) begin
                        w_state_nxt = c_IDLE;
                        w_tmr_nxt   = '0;
                        w_tone_nxt  = '0;
                        w_buz_nxt   = 1'b0;
                        w_beeps_nxt = '0;
                    end else if (r_state == c_BEEP_ON) begin
                        if (r_tone == r_div) begin
                            w_tone_nxt = '0;
                            w_buz_nxt  = ~r_buzzer;
                        end else begin
                            w_tone_nxt = r_tone + 1'b1;
                        end
                        if (r_tmr == r_len) begin
                            w_state_nxt = c_BEEP_OFF;
                            w_tmr_nxt   = '0;
                            w_tone_nxt  = '0;
                            w_buz_nxt   = 1'b0;
                            w_gap_nxt   = beep_gap;
                        end else begin
                            w_tmr_nxt = r_tmr + 1'b1;
                        end
                    end else if (r_tmr == r_gap) begin
                        w_tmr_nxt = '0;
                        if (w_last) begin
                            w_state_nxt = c_IDLE;
                            w_beeps_nxt = '0;
                        end else begin
                            w_state_nxt = c_BEEP_ON;
                            w_beeps_nxt = r_beeps + 1'b1;
                            w_tone_nxt  = '0;
                            w_buz_nxt   = 1'b0;
                            w_len_nxt   = beep_len;
                            w_div_nxt   = tone_div;
                        end
                    end else begin
                        w_tmr_nxt = r_tmr + 1'b1;
                    end
                end
                c_FAULT: begin
                    if (!fault) begin
                        w_state_nxt = c_IDLE;
                        w_tone_nxt  = '0;
                        w_buz_nxt   = 1'b0;
                    end else if (r_tone == r_div) begin
                        w_tone_nxt = '0;
                        w_buz_nxt  = ~r_buzzer;
                    end else begin
                        w_tone_nxt = r_tone + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = c_IDLE;
                    w_buz_nxt   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_match_q   <= '0;
            r_pending   <= '0;
            r_state     <= c_IDLE;
            r_tmr       <= '0;
            r_tone      <= '0;
            r_buzzer    <= 1'b0;
            r_beeps     <= '0;
            r_active_ch <= '0;
            r_rr        <= '0;
            r_len       <= '0;
            r_gap       <= '0;
            r_div       <= '0;
            r_num       <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_match_q   <= w_match;
            r_pending   <= w_pend_nxt;
            r_state     <= w_state_nxt;
            r_tmr       <= w_tmr_nxt;
            r_tone      <= w_tone_nxt;
            r_buzzer    <= w_buz_nxt;
            r_beeps     <= w_beeps_nxt;
            r_active_ch <= w_active_nxt;
            r_rr        <= w_rr_nxt;
            r_len       <= w_len_nxt;
            r_gap       <= w_gap_nxt;
            r_div       <= w_div_nxt;
            r_num       <= w_num_nxt;
            r_busy      <= (w_state_nxt != c_IDLE);
        end
    end

    assign lane_if.alarm     = r_pending;
    assign lane_if.active_ch = r_active_ch;
    assign buzzer            = r_buzzer;
    assign busy              = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_alarm_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_controller
// Description : Directed and random checks of alarm_controller against a
//               timeline-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_controller;
    localparam int N  = 4;
    localparam int AC = 1;

    logic        clk = 1'b0;
    logic        rst_n, enable, fault;
    logic [15:0] tone_div, beep_len, beep_gap;
    logic [3:0]  beep_num;
    logic        buzzer, busy;
    logic [7:0]  cur [N];
    logic [7:0]  tgt [N];
    logic [N-1:0] ack_v;
    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 idle, 1 burst, 2 fault; m_t counts cycles in mode
    int m_mode, m_t, m_lane, m_rr, m_act, m_len, m_gap, m_div, m_num, m_fdiv;
    logic [N-1:0] m_pend, m_prev;

    alarm_controller_if #(.N_CH(N), .CNT_W(8)) lif ();
    assign lif.current_count = {cur[3], cur[2], cur[1], cur[0]};
    assign lif.target_count  = {tgt[3], tgt[2], tgt[1], tgt[0]};
    assign lif.ack           = ack_v;

    alarm_controller #(.N_CH(N), .CNT_W(8), .DIV_W(16), .NUM_W(4), .AUTO_CLEAR(AC)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fault(fault),
        .tone_div(tone_div), .beep_len(beep_len), .beep_gap(beep_gap), .beep_num(beep_num),
        .lane_if(lif), .buzzer(buzzer), .busy(busy));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_mode = 0; m_t = 0; m_lane = 0; m_rr = 0; m_act = 0;
        m_len = 0; m_gap = 0; m_div = 0; m_num = 1; m_fdiv = 0;
        m_pend = '0; m_prev = '0;
    endtask

    task automatic model_step();
        logic [N-1:0] match, rise, clr, nxt;
        int p, o, b, nm, nt;
        bit done, found;
        for (int i = 0; i < N; i++) match[i] = (cur[i] == tgt[i]) && (tgt[i] != 0);
        rise = match & ~m_prev;
        done = 1'b0;
        clr  = '0;
        if (m_mode == 1) begin
            p = m_len + m_gap + 2; o = m_t % p; b = m_t / p;
            done = (o == p - 1) && (b + 1 == m_num);
        end
        if (done && enable && !fault && AC != 0) clr[m_lane] = 1'b1;
        nxt = (m_pend & ~ack_v & ~clr) | rise;
        nm = m_mode; nt = m_t + 1;
        if (!enable) nm = 0;
        else if (m_mode == 0) begin
            if (fault) begin
                nm = 2; nt = 0; m_fdiv = int'(tone_div >> 1);
            end else if (m_pend != 0) begin
                found = 1'b0;
                for (int k = 0; k < N; k++)
                    if (!found && m_pend[(m_rr + k) % N]) begin
                        found = 1'b1; m_lane = (m_rr + k) % N;
                    end
                m_rr = (m_lane + 1) % N; m_act = m_lane; nm = 1; nt = 0;
                m_len = int'(beep_len); m_gap = int'(beep_gap); m_div = int'(tone_div);
                m_num = (beep_num == 0) ? 1 : int'(beep_num);
            end
        end else if (m_mode == 1) begin
            if (fault) begin
                nm = 2; nt = 0; m_fdiv = int'(tone_div >> 1);
            end else if (!nxt[m_lane] || done) nm = 0;
        end else if (!fault) nm = 0;
        m_mode = nm; m_t = nt; m_pend = nxt; m_prev = match;
    endtask

    function automatic logic exp_buz();
        int p, o;
        if (m_mode == 1) begin
            p = m_len + m_gap + 2; o = m_t % p;
            if (o <= m_len) return ((o / (m_div + 1)) % 2) == 1;
            return 1'b0;
        end
        if (m_mode == 2) return ((m_t / (m_fdiv + 1)) % 2) == 1;
        return 1'b0;
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("alarm", 32'(lif.alarm), 32'(m_pend));
        chk("active_ch", 32'(lif.active_ch), 32'(m_act));
        chk("buzzer", 32'(buzzer), 32'(exp_buz()));
        chk("busy", 32'(busy), 32'(m_mode != 0));
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (busy && n < lim) begin step(); n++; end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [23:0] pat;
        logic [14:0] fpat;
        int bursts;
        logic pbusy;
        rst_n = 1'b0; enable = 1'b1; fault = 1'b0; ack_v = '0;
        tone_div = 16'd1; beep_len = 16'd7; beep_gap = 16'd3; beep_num = 4'd2;
        for (int i = 0; i < N; i++) begin cur[i] = 8'd0; tgt[i] = 8'd50; end
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("rst_alarm", 32'(lif.alarm), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_buzzer", 32'(buzzer), 32'd0);
        chk("rst_active", 32'(lif.active_ch), 32'd0);
        repeat (3) step();

        // single lane burst on lane 2
        cur[2] = 8'd50; step();
        chk("sl_alarm", 32'(lif.alarm), 32'b0100);
        step();
        chk("sl_busy", 32'(busy), 32'd1);
        chk("sl_active", 32'(lif.active_ch), 32'd2);
        pat = {23'd0, buzzer};
        for (int c = 0; c < 23; c++) begin step(); pat = {pat[22:0], buzzer}; end
        chk("sl_pattern", 32'(pat), 32'(24'b0011_0011_0000_0011_0011_0000));
        step();
        chk("sl_done_busy", 32'(busy), 32'd0);
        chk("sl_done_alarm", 32'(lif.alarm), 32'd0);
        cur[2] = 8'd0; step();

        // round-robin: serve lane 0 so the pointer lands on 1
        cur[0] = 8'd50; step(); step(); wait_idle(100);
        cur[0] = 8'd0; step();
        cur[0] = 8'd50; cur[3] = 8'd50; step();
        chk("rr_alarm", 32'(lif.alarm), 32'b1001);
        step();
        chk("rr_first", 32'(lif.active_ch), 32'd3);
        wait_idle(100);
        step();
        chk("rr_second", 32'(lif.active_ch), 32'd0);
        chk("rr_second_busy", 32'(busy), 32'd1);
        wait_idle(100);
        cur[0] = 8'd0; cur[3] = 8'd0; step();

        // ack coinciding with a rise keeps the event; ack on active lane aborts
        ack_v = 4'b0010; cur[1] = 8'd50; step();
        chk("ack_vs_rise", 32'(lif.alarm[1]), 32'd1);
        ack_v = '0; step();
        chk("ack_active", 32'(lif.active_ch), 32'd1);
        step(); step();
        ack_v = 4'b0010; step();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_buzzer", 32'(buzzer), 32'd0);
        ack_v = '0; cur[1] = 8'd0; step();

        // fault preemption
        tone_div = 16'd8; beep_len = 16'd30;
        cur[3] = 8'd50; step(); step();
        repeat (3) step();
        fault = 1'b1; step();
        fpat = {14'd0, buzzer};
        chk("fault_busy", 32'(busy), 32'd1);
        for (int c = 0; c < 14; c++) begin step(); fpat = {fpat[13:0], buzzer}; end
        chk("fault_pattern", 32'(fpat), 32'(15'b00000_11111_00000));
        chk("fault_pending", 32'(lif.alarm[3]), 32'd1);
        fault = 1'b0; step();
        chk("fault_exit_busy", 32'(busy), 32'd0);
        step();
        chk("fault_restart", 32'(lif.active_ch), 32'd3);
        wait_idle(200);
        cur[3] = 8'd0; step();

        // count held at target gives exactly one burst
        tone_div = 16'd1; beep_len = 16'd2; beep_gap = 16'd1; beep_num = 4'd1;
        cur[0] = 8'd50; bursts = 0; pbusy = busy;
        for (int c = 0; c < 100; c++) begin
            step();
            if (busy && !pbusy) bursts++;
            pbusy = busy;
        end
        chk("hold_bursts", 32'(bursts), 32'd1);
        cur[0] = 8'd0; step();

        // mute
        cur[2] = 8'd50; step(); step(); step();
        enable = 1'b0; step();
        chk("mute_busy", 32'(busy), 32'd0);
        chk("mute_buzzer", 32'(buzzer), 32'd0);
        cur[1] = 8'd50; step();
        chk("mute_alarm", 32'(lif.alarm[1]), 32'd1);
        enable = 1'b1;
        repeat (2) begin step(); wait_idle(100); end
        cur[1] = 8'd0; cur[2] = 8'd0; step();

        // randomized segments
        for (int seg = 0; seg < 6; seg++) begin
            enable = 1'b0; fault = 1'b0; ack_v = '0; step();
            tone_div = 16'($urandom_range(0, 3));
            beep_len = 16'($urandom_range(0, 5));
            beep_gap = 16'($urandom_range(0, 4));
            beep_num = 4'($urandom_range(0, 3));
            for (int i = 0; i < N; i++) tgt[i] = 8'($urandom_range(0, 3));
            enable = 1'b1;
            for (int c = 0; c < 300; c++) begin
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(0, 7) == 0) cur[i] = 8'($urandom_range(0, 3));
                    ack_v[i] = ($urandom_range(0, 31) == 0);
                end
                if ($urandom_range(0, 79) == 0) fault = ~fault;
                enable = ($urandom_range(0, 99) != 0);
                step();
            end
        end

        // asynchronous reset in the middle of a burst
        enable = 1'b1; fault = 1'b0; ack_v = '0;
        for (int i = 0; i < N; i++) begin cur[i] = 8'd0; tgt[i] = 8'd50; end
        tone_div = 16'd1; beep_len = 16'd7; beep_gap = 16'd3; beep_num = 4'd2;
        step();
        cur[2] = 8'd50;
        for (int n = 0; n < 200 && !busy; n++) step();
        step(); step();
        rst_n = 1'b0; #1;
        chk("arst_alarm", 32'(lif.alarm), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_buzzer", 32'(buzzer), 32'd0);
        chk("arst_active", 32'(lif.active_ch), 32'd0);
        cur[2] = 8'd0;
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        m_reset();
        repeat (3) step();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_buzzer", 32'(buzzer), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Multi-lane successor to the single-lane fill-complete alarm in the pill bottling system.
- Watches N_CH bottling lanes and latches a per-lane "bottle full" event when a lane's count reaches its target.
- Arbitrates round-robin among pending lanes and drives one shared buzzer with a programmable beep burst.
- A fault input preempts everything with a distinct fast continuous tone. Sits between the lane counters and the board buzzer/LEDs.

Parameters:
- N_CH, 4, number of bottling lanes (1..8).
- CNT_W, 8, width of each lane's count/target.
- DIV_W, 16, width of tone divider and beep timing inputs.
- NUM_W, 4, width of beep-per-burst count.
- AUTO_CLEAR, 1: a lane's pending flag clears when its burst completes. 0: flag persists until ack.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- enable, input, 1, 0 = mute/hold: FSM forced to IDLE, buzzer 0, pending flags still tracked.
- current_count, input, N_CH*CNT_W, lane i at bits [i*CNT_W +: CNT_W].
- target_count, input, N_CH*CNT_W, packed the same way.
- ack, input, N_CH, per-lane acknowledge (level, sampled each clk).
- fault, input, 1, machine fault request.
- tone_div, input, DIV_W, buzzer toggles every tone_div+1 cycles.
- beep_len, input, DIV_W, beep on-time = beep_len+1 cycles.
- beep_gap, input, DIV_W, beep off-time = beep_gap+1 cycles.
- beep_num, input, NUM_W, beeps per burst; 0 treated as 1.
- alarm, output, N_CH, registered pending flags (lane LEDs).
- active_ch, output, max(1,$clog2(N_CH)), lane currently being sounded.
- buzzer, output, 1, buzzer drive.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Reset: alarm=0, active_ch=0, buzzer=0, busy=0, FSM=IDLE, all counters 0, round-robin pointer=0.
- Event detect: match_i = (current_i == target_i) && (target_i != 0). A registered copy of match gives a rising edge. pending_i sets on the rising edge only; a count held at target never re-triggers.
- Set/clear priority:
  - ack_i clears pending_i.
  - A rising edge in the same cycle as ack_i leaves pending_i set; an event is never lost.
- alarm mirrors pending with no extra latency: alarm_i is high the cycle after the rising edge is registered.
- FSM states: IDLE, BEEP_ON, BEEP_OFF, FAULT.
- IDLE:
  - fault && enable → FAULT.
  - Otherwise, any pending → pick the first pending lane scanning from rr_ptr upward with wrap, latch active_ch, set rr_ptr=active_ch+1 mod N_CH, zero the beep counter → BEEP_ON.
- BEEP_ON:
  - Buzzer starts 0 on entry and toggles each time the tone counter hits tone_div; the tone counter then resets.
  - After beep_len+1 cycles → BEEP_OFF with buzzer forced 0.
- BEEP_OFF:
  - After beep_gap+1 cycles, beeps++.
  - If beeps == max(beep_num,1) → burst done → IDLE. With AUTO_CLEAR=1, pending[active_ch] clears in that same cycle.
  - Otherwise → BEEP_ON.
- Abort: pending[active_ch] cleared by ack during BEEP_ON/BEEP_OFF → IDLE next cycle with buzzer=0. The burst is not resumed.
- FAULT:
  - Continuous tone, toggling every (tone_div>>1)+1 cycles.
  - fault low → IDLE with buzzer 0.
  - fault wins over burst activity: from BEEP_ON/BEEP_OFF, fault → FAULT next cycle and the burst is abandoned (pending retained).
- enable=0: next cycle FSM=IDLE, buzzer=0. Counters are cleared; pending flags keep updating.
- tone_div=0 → buzzer toggles every cycle in BEEP_ON. beep_len=0 → one-cycle beep.
- Counters wrap-safe: every compare is equality against an input latched at state entry. tone_div/beep_len/beep_gap changes mid-beep take effect from the next state entry.
- All outputs registered; no combinational input→output paths.

Test Plan:
- Reset then idle: rst_n low mid-burst → all outputs 0 within the same cycle; after release, busy=0 and buzzer=0 with no counts at target.
- Single lane burst:
  - Setup: N_CH=4, lane 2 count 0→50 with target 50, tone_div=1, beep_len=7, beep_gap=3, beep_num=2.
  - Response: alarm=0100, active_ch=2, two 8-cycle beeps toggling every 2 cycles with 4-cycle gaps, then busy=0 and alarm=0000 (AUTO_CLEAR=1).
- Round-robin: lanes 0 and 3 rise in the same cycle with rr_ptr=1 → lane 3 served first, then lane 0.
- Ack vs event: ack[1] high in the same cycle as lane 1's rising match → alarm[1] stays 1. Ack during BEEP_ON on the active lane → buzzer 0 and IDLE next cycle.
- Fault preemption: fault high mid-BEEP_ON with tone_div=8 → FAULT next cycle, buzzer toggles every 5 cycles, pending retained. Fault low → burst restarts via arbitration.
- Hold and mute: lane count held at target for 100 cycles → exactly one burst. enable=0 → buzzer 0 next cycle; a new match still sets alarm.
